// File: rtl/mult_ctrl_unit.sv
// mult_ctrl_unit: sign-magnitude multiply sequencer driving an external shift-add datapath
module mult_ctrl_unit #(
    parameter int N_BITS     = 6,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS:0]   a_in,
    input  logic [N_BITS:0]   b_in,
    output logic              dp_start,
    output logic              dp_done,
    output logic [N_BITS:0]   dp_a,
    output logic [N_BITS:0]   dp_b,
    input  logic [2*N_BITS:0] dp_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*N_BITS:0] out_prod,
    output logic              busy
);
    localparam int CW = $clog2(N_BITS + SETTLE_CYC + 1);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, SETTLE, HOLD} state_t;
    state_t              state;
    logic [CW-1:0]       cnt;
    logic                sign;
    logic [2*N_BITS-1:0] mag;
    logic                unused_prod_msb;
    assign mag             = dp_prod[2*N_BITS-1:0];
    assign unused_prod_msb = dp_prod[2*N_BITS];
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sign      <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            dp_start  <= 1'b0;
            dp_done   <= 1'b1;
            dp_a      <= '0;
            dp_b      <= '0;
            out_valid <= 1'b0;
            out_prod  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    dp_a     <= {1'b0, a_in[N_BITS-1:0]};
                    dp_b     <= {1'b0, b_in[N_BITS-1:0]};
                    sign     <= a_in[N_BITS] ^ b_in[N_BITS];
                    state    <= LOAD;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    dp_start <= 1'b1;
                    dp_done  <= 1'b0;
                end
                LOAD: begin
                    state    <= RUN;
                    dp_start <= 1'b0;
                    cnt      <= '0;
                end
                RUN: if (cnt == CW'(N_BITS - 1)) begin
                    state   <= SETTLE;
                    dp_done <= 1'b1;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // the sign is dropped for a zero magnitude so -0 never leaves the block
                SETTLE: if (cnt == CW'(SETTLE_CYC - 1)) begin
                    state     <= HOLD;
                    cnt       <= '0;
                    out_valid <= 1'b1;
                    out_prod  <= {sign && (mag != '0), mag};
                end else begin
                    cnt <= cnt + 1'b1;
                end
                HOLD: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_ctrl_unit.sv
// tb_mult_ctrl_unit: directed and random checks of mult_ctrl_unit with a behavioural shift-add datapath
module tb_mult_ctrl_unit;
    logic        clk, rst, in_valid, in_ready, dp_start, dp_done, out_valid, out_ready, busy;
    logic [6:0]  a_in, b_in, dp_a, dp_b;
    logic [12:0] dp_prod, out_prod;
    logic [12:0] acc, mc;
    logic [6:0]  mp;
    int checks = 0, errors = 0, n_in = 0, n_out = 0, exp_hs = 0, exp_out = 0;

    mult_ctrl_unit #(.N_BITS(6), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .dp_start(dp_start), .dp_done(dp_done),
        .dp_a(dp_a), .dp_b(dp_b), .dp_prod(dp_prod), .out_valid(out_valid),
        .out_ready(out_ready), .out_prod(out_prod), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // shift-add datapath: loads on dp_start, steps every cycle dp_done is low
    always @(posedge clk) begin
        if (dp_start) begin
            acc <= '0;
            mc  <= {6'b0, dp_a};
            mp  <= dp_b;
        end else if (!dp_done) begin
            acc <= acc + (mp[0] ? mc : 13'd0);
            mc  <= mc << 1;
            mp  <= mp >> 1;
        end
    end
    assign dp_prod = acc;

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) n_in <= n_in + 1;
        if (!rst && out_valid && out_ready) n_out <= n_out + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [6:0] a, input logic [6:0] b, input logic [12:0] exp,
                         input int stall, input bit noise);
        int n, starts, runs;
        check("idle_ready", 32'(in_ready), 32'd1);
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        @(negedge clk);
        exp_hs++;
        exp_out++;
        in_valid = noise;
        n = 1;
        starts = 0;
        runs = 0;
        while (!out_valid && n < 40) begin
            starts += 32'(dp_start);
            runs += 32'(!dp_start && !dp_done);
            if (noise) begin
                a_in = 7'($urandom);
                b_in = 7'($urandom);
            end
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd10);
        check("start_cycles", 32'(starts), 32'd1);
        check("run_cycles", 32'(runs), 32'd6);
        check("prod", 32'(out_prod), 32'(exp));
        check("dp_a", 32'(dp_a), 32'({1'b0, a[5:0]}));
        check("dp_b", 32'(dp_b), 32'({1'b0, b[5:0]}));
        repeat (stall) begin
            out_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_prod", 32'(out_prod), 32'(exp));
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [6:0]  a, b;
        logic [11:0] m;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dp_start", 32'(dp_start), 32'd0);
        check("rst_dp_done", 32'(dp_done), 32'd1);
        check("rst_dp_a", 32'(dp_a), 32'd0);
        check("rst_dp_b", 32'(dp_b), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_prod", 32'(out_prod), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(7'h05, 7'h03, 13'h000F, 0, 1'b0);
        do_op(7'h45, 7'h03, 13'h100F, 1, 1'b0);
        do_op(7'h45, 7'h43, 13'h000F, 0, 1'b0);
        do_op(7'h3F, 7'h3F, 13'h0F81, 2, 1'b0);
        do_op(7'h40, 7'h09, 13'h0000, 0, 1'b0);
        do_op(7'h05, 7'h03, 13'h000F, 5, 1'b1);

        // reset lands in RUN cycle 3 together with in_valid and out_ready
        a_in = 7'h02;
        b_in = 7'h03;
        in_valid = 1'b1;
        @(negedge clk);
        exp_hs++;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("midrun_dp_done", 32'(dp_done), 32'd1);
        check("midrun_out_valid", 32'(out_valid), 32'd0);
        check("midrun_in_ready", 32'(in_ready), 32'd1);
        check("midrun_busy", 32'(busy), 32'd0);
        check("midrun_dp_start", 32'(dp_start), 32'd0);
        check("midrun_dp_a", 32'(dp_a), 32'd0);
        do_op(7'h02, 7'h03, 13'h0006, 0, 1'b0);

        for (int i = 0; i < 100; i++) begin
            a = 7'($urandom);
            b = 7'($urandom);
            m = 12'(a[5:0]) * 12'(b[5:0]);
            do_op(a, b, {(a[6] ^ b[6]) && (m != 12'd0), m}, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        check("in_handshakes", 32'(n_in), 32'(exp_hs));
        check("out_handshakes", 32'(n_out), 32'(exp_out));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
